// File: rtl/int_pow_pkg.sv
// Shared definitions for the integer power unit: default sizes and FSM state encoding.
package int_pow_pkg;

  localparam int unsigned DefWidth    = 16;
  localparam int unsigned DefExpWidth = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/int_pow_mul.sv
// Unsigned WIDTH x WIDTH multiplier returning the low half and an upper-half-nonzero flag.
module int_pow_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nz
);

  logic [2*WIDTH-1:0] prod;

  // Full-width product, split into the kept low half and a truncation flag.
  always_comb begin
    prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    lo    = prod[WIDTH-1:0];
    hi_nz = |prod[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/int_pow.sv
// Fixed-latency square-and-multiply power unit: result = base**exponent mod 2**WIDTH,
// with a flag reporting whether the true power reached 2**WIDTH.
module int_pow
  import int_pow_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned EXP_WIDTH = DefExpWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
);

  localparam int unsigned         CntWidth = $clog2(EXP_WIDTH + 1);
  localparam logic [CntWidth-1:0] CntLoad  = CntWidth'(EXP_WIDTH);
  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic                 b_ovf_q, b_ovf_d;
  logic                 ovf_q, ovf_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;

  logic [WIDTH-1:0]     acc_prod;
  logic                 acc_hi_nz;
  logic [WIDTH-1:0]     sq_prod;
  logic                 sq_hi_nz;

  int_pow_mul #(
    .WIDTH(WIDTH)
  ) u_mul_acc (
    .a    (acc_q),
    .b    (b_q),
    .lo   (acc_prod),
    .hi_nz(acc_hi_nz)
  );

  int_pow_mul #(
    .WIDTH(WIDTH)
  ) u_mul_sq (
    .a    (b_q),
    .b    (b_q),
    .lo   (sq_prod),
    .hi_nz(sq_hi_nz)
  );

  // Next-state logic: capture on start, one exponent bit per RUN cycle, publish on exit.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    b_d        = b_q;
    e_d        = e_q;
    b_ovf_d    = b_ovf_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    ready      = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          acc_d   = WIDTH'(1);
          b_d     = base;
          e_d     = exponent;
          b_ovf_d = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = CntLoad;
          state_d = StRun;
        end
      end
      StRun: begin
        if (e_q[0]) begin
          acc_d = acc_prod;
          // A wrapped b only matters once an exponent bit actually consumes it.
          ovf_d = ovf_q | acc_hi_nz | b_ovf_q;
        end
        b_d     = sq_prod;
        b_ovf_d = b_ovf_q | sq_hi_nz;
        e_d     = e_q >> 1;
        cnt_d   = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
          // Publish on the DONE-entry edge so result is valid while done is high.
          result_d   = acc_d;
          overflow_d = ovf_d;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      b_q        <= '0;
      e_q        <= '0;
      b_ovf_q    <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      e_q        <= e_d;
      b_ovf_q    <= b_ovf_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_int_pow.sv
// Randomised and directed bench for int_pow against an arithmetic power model.
module tb_int_pow;

  localparam int unsigned W   = 16;
  localparam int unsigned EW  = 5;
  localparam int unsigned Lat = EW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exponent;
  logic          ready;
  logic          done;
  logic [W-1:0]  result;
  logic          overflow;

  int n_tests;
  int n_fail;

  int_pow #(
    .WIDTH    (W),
    .EXP_WIDTH(EW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .exponent(exponent),
    .ready   (ready),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    n_tests++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Repeated multiplication; the true value saturates at 2**W since only the threshold matters.
  function automatic void model(input int unsigned bs, input int unsigned ex,
                                output longint res, output longint ovf);
    longint unsigned low;
    longint unsigned true_v;
    low    = 1;
    true_v = 1;
    for (int i = 0; i < int'(ex); i++) begin
      low    = (low * bs) % (64'd1 << W);
      true_v = true_v * bs;
      if (true_v > (64'd1 << W)) true_v = 64'd1 << W;
    end
    res = longint'(low);
    ovf = (true_v >= (64'd1 << W)) ? 1 : 0;
  endfunction

  // mode 0: plain op; 1: extra start during RUN; 2: reset at cycle 3 of the run.
  // Entered and left on a negedge with the DUT idle, so calls chain back to back.
  task automatic run_op(input int unsigned bs, input int unsigned ex, input int mode,
                        input longint exp_res, input longint exp_ovf);
    int lat;
    int guard;
    int seen;
    guard = 0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      check("ready_wait", 0, 1);
      return;
    end
    base     = W'(bs);
    exponent = EW'(ex);
    start    = 1'b1;
    lat      = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start    = 1'b0;
        base     = W'($urandom);
        exponent = EW'($urandom);
        check("ready_in_run", ready, 0);
      end
      if (mode == 1 && lat == 2) begin
        start    = 1'b1;
        base     = W'(7);
        exponent = EW'(3);
      end
      if (mode == 1 && lat == 3) start = 1'b0;
      if (mode == 2 && lat == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_ovf", overflow, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        return;
      end
    end while (!done && lat < 20);
    check($sformatf("latency b=%0d e=%0d", bs, ex), lat, Lat);
    check($sformatf("result b=%0d e=%0d", bs, ex), result, exp_res);
    check($sformatf("ovf b=%0d e=%0d", bs, ex), overflow, exp_ovf);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("ready_after", ready, 1);
    check("result_held", result, exp_res);
  endtask

  initial begin
    longint r;
    longint o;
    int unsigned bs;
    int unsigned ex;
    int seen;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    base     = '0;
    exponent = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with hand-derived expectations, issued back to back.
    run_op(3, 4, 0, 81, 0);
    run_op(2, 15, 0, 32768, 0);
    run_op(2, 16, 0, 0, 1);
    run_op(5, 7, 0, 12589, 1);
    run_op(0, 0, 0, 1, 0);
    run_op(255, 2, 0, 65025, 0);
    run_op(0, 9, 0, 0, 0);
    run_op(1, 31, 0, 1, 0);
    run_op(65535, 0, 0, 1, 0);
    run_op(3, 4, 1, 81, 0);
    run_op(9, 5, 2, 0, 0);

    // Reset wins over a simultaneous start.
    rst      = 1'b1;
    start    = 1'b1;
    base     = W'(3);
    exponent = EW'(4);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_prio_ready", ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rst_prio_no_done", seen, 0);

    // Random operations, biased toward small bases so both overflow outcomes occur.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       bs = $urandom_range(0, 3);
        1:       bs = $urandom_range(0, 15);
        2:       bs = $urandom_range(0, 255);
        default: bs = $urandom_range(0, 65535);
      endcase
      ex = $urandom_range(0, 31);
      model(bs, ex, r, o);
      run_op(bs, ex, 0, r, o);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_pow.md
INT_POW -- requirements
Module: int_pow

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 5, giving the exponent width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 base  input  WIDTH  unsigned base; captured on accepted start.
REQ-007 exponent  input  EXP_WIDTH  unsigned exponent; captured on accepted start.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  one-cycle pulse when result is valid.
REQ-010 result  output  WIDTH  base**exponent mod 2**WIDTH; held until the next accepted start.
REQ-011 overflow  output  1  high when the true power is at least 2**WIDTH; held with result.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 IDLE -> RUN on start=1: capture acc=1, b=base, e=exponent, clear b_ovf and ovf, and load cnt=EXP_WIDTH.
REQ-014 Each RUN cycle SHALL:
  - if e[0]=1: set acc = low WIDTH bits of acc*b, and set ovf if the product upper half is nonzero or b_ovf=1;
  - set b = low WIDTH bits of b*b, and set b_ovf if the upper half is nonzero;
  - shift e right by 1 and decrement cnt.
REQ-015 RUN SHALL last exactly EXP_WIDTH cycles regardless of exponent value (fixed latency), then go to DONE.
REQ-016 DONE SHALL:
  - drive done=1 for one cycle;
  - update result=acc and overflow=ovf in the same cycle;
  - then return to IDLE.
REQ-017 Latency SHALL be exactly EXP_WIDTH+1 cycles from the cycle start is sampled to the cycle done=1.
REQ-018 start while ready=0 SHALL be ignored with no effect on the operation in progress.
REQ-019 exponent=0 SHALL yield result=1 and overflow=0 for any base, including base=0.
REQ-020 base=0 with exponent>0 SHALL yield result=0 and overflow=0.
REQ-021 base=1 SHALL never set overflow.
REQ-022 b_ovf SHALL affect ovf only when a later exponent bit consumes b; squaring overflow after the last used bit SHALL NOT set overflow.
REQ-023 Back-to-back operation: start asserted in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-024 rst=1 SHALL force, at the next clock edge:
  - state=IDLE, ready=1, done=0, result=0, overflow=0;
  - all internal registers to 0.
REQ-025 rst during RUN or DONE SHALL abort the operation with no done pulse.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 A shared package int_pow_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and the default WIDTH/EXP_WIDTH values.
REQ-028 The cnt width SHALL be derived with $clog2(EXP_WIDTH+1).
REQ-029 One sub-module int_pow_mul (WIDTH x WIDTH unsigned multiply) SHALL provide the low WIDTH bits and an upper-half-nonzero flag.
REQ-030 int_pow SHALL instantiate int_pow_mul twice: one for acc*b, one for b*b.

Verification (WIDTH=16, EXP_WIDTH=5)
REQ-031 base=3, exponent=4, start for one cycle -> done exactly 6 cycles later, result=81, overflow=0, ready=0 during RUN.
REQ-032 base=2, exponent=15 -> result=32768, overflow=0; then base=2, exponent=16 -> result=0, overflow=1.
REQ-033 base=5, exponent=7 -> result=12589 (78125 mod 65536), overflow=1; then base=0, exponent=0 -> result=1, overflow=0.
REQ-034 base=255, exponent=2 -> result=65025, overflow=0; the squaring overflow of b is unused and SHALL NOT set overflow.
REQ-035 Start base=3, exponent=4, pulse start again at cycle 2 with base=7, exponent=3 -> the second start is ignored and result=81; rst asserted at cycle 3 of a new run -> no done, ready=1, result=0 next cycle.
